jump_target_unit: RTL and testbench
===================================

// Module: jump_target_unit
// PURPOSE
//   Parametrised, registered PC-target generator for the multicycle datapath. It replaces the
//   combinational jump shifter and feeds the PC-source mux. Per accepted request it computes
//   one target: jump ({pc_hi, index, zeros}), branch (pc+step+sext(offset)<<SHIFT), or register.
//   A small return-address stack (RAS) checks JR-$ra returns against the value pushed by JAL.
// PARAMETERS
//   ADDR_W    32  address width; 4 MSBs of pc are kept on jumps; INDEX_W = ADDR_W-4-SHIFT (26)
//   SHIFT     2   left-shift applied to index/offset; step = 1<<SHIFT (4)
//   OFF_W     16  branch offset width, sign-extended to ADDR_W before the shift
//   RAS_DEPTH 4   RAS entries (power of 2, >=2)
// PORTS
//   clk          in   1        clock; all state changes on the rising edge
//   reset        in   1        synchronous, active-high
//   req_valid    in   1        request present
//   req_ready    out  1        unit can accept a request
//   op           in   3        000 J, 001 JAL, 010 BRANCH, 011 JR, 100 RET (JR $ra), others illegal
//   pc           in   ADDR_W   address of the jump/branch instruction (not incremented)
//   instr_index  in   INDEX_W  instruction field {rs,rt,imm}
//   offset       in   OFF_W    branch immediate
//   rs_val       in   ADDR_W   register operand for JR/RET
//   br_taken     in   1        branch condition from the ALU; sampled with the request
//   tgt_valid    out  1        tgt_addr and its flags are valid
//   tgt_ready    in   1        consumer accepts the target
//   tgt_addr     out  ADDR_W   computed next PC
//   link_addr    out  ADDR_W   pc+step; meaningful for JAL
//   ras_hit      out  1        RET only: popped entry == rs_val
//   ras_empty    out  1        RET only: pop attempted on an empty RAS
//   op_err       out  1        illegal op; tgt_addr = pc+step
// BEHAVIOUR
//   States:
//   - IDLE: req_ready=1. req_valid -> CALC; latch all inputs.
//   - CALC: req_ready=0, one cycle. Target is registered, RAS is updated, -> HOLD.
//   - HOLD: tgt_valid=1; outputs stay stable until tgt_ready. tgt_ready -> IDLE.
//   Latency and throughput:
//   - tgt_valid rises 2 cycles after the accept edge.
//   - At most one request is in flight; no back-to-back accept from HOLD.
//   Reset:
//   - Returns to IDLE; tgt_valid=0; req_ready=1.
//   - tgt_addr, link_addr, ras_hit, ras_empty, op_err all = 0.
//   - RAS pointer = 0, count = 0.
//   - Reset mid-operation discards the request without any RAS update.
//   Arithmetic (all mod 2^ADDR_W; carries dropped):
//   - J/JAL: tgt = {pc[ADDR_W-1:ADDR_W-4], instr_index, SHIFT'b0}.
//   - BRANCH: tgt = br_taken ? pc+step+(sext(offset)<<SHIFT) : pc+step.
//   - JR/RET: tgt = rs_val unmodified; no alignment check.
//   RAS:
//   - JAL pushes pc+step in CALC.
//   - Full push overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
//   - RET pops in CALC. Non-empty: ras_hit = (entry == rs_val), ras_empty=0.
//   - Empty RET: no pointer change, ras_hit=0, ras_empty=1.
//   - ras_hit, ras_empty = 0 for every op except RET. J, BRANCH and JR leave the RAS untouched.
//   - RET target is always rs_val; the RAS is a checker only, never a predictor.
// TESTING
//   - J, pc=0xA000_0010, index=0x0000123 -> tgt_addr=0xA000_048C, op_err=0, 2 cycles after accept.
//   - BRANCH, pc=0x0040_0100, offset=0xFFFE:
//     - taken -> tgt_addr=0x0040_00FC
//     - not taken -> tgt_addr=0x0040_0104
//   - JAL at pc=0x0040_0020, then RET with rs_val=0x0040_0024 -> ras_hit=1, ras_empty=0.
//     - Same with rs_val=0x0040_0028 -> ras_hit=0, tgt_addr=0x0040_0028.
//   - 5 JALs at pc=0x10,0x20,..,0x50, then 5 RETs:
//     - first 4 pop 0x54,0x44,0x34,0x24
//     - 5th RET -> ras_empty=1
//   - Backpressure: tgt_ready=0 for 6 cycles -> outputs stable, req_ready=0; accept -> IDLE next cycle.
//   - Reset asserted in CALC of a JAL -> tgt_valid=0, RAS count stays 0; op=3'b111 -> op_err=1, tgt=pc+4.

Source files
------------

// File: rtl/jump_target_unit.sv
// rtl/jump_target_unit.sv - registered PC-target generator with return-address checker stack
module jump_target_unit #(
  parameter int ADDR_W    = 32,
  parameter int SHIFT     = 2,
  parameter int OFF_W     = 16,
  parameter int RAS_DEPTH = 4,
  localparam int INDEX_W  = ADDR_W - 4 - SHIFT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         op,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INDEX_W-1:0] instr_index,
  input  logic [OFF_W-1:0]   offset,
  input  logic [ADDR_W-1:0]  rs_val,
  input  logic               br_taken,
  output logic               tgt_valid,
  input  logic               tgt_ready,
  output logic [ADDR_W-1:0]  tgt_addr,
  output logic [ADDR_W-1:0]  link_addr,
  output logic               ras_hit,
  output logic               ras_empty,
  output logic               op_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_J   = 3'd0;
  localparam logic [2:0] OP_JAL = 3'd1;
  localparam logic [2:0] OP_BR  = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state;

  logic [2:0]         op_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  rs_q;
  logic [INDEX_W-1:0] idx_q;
  logic [OFF_W-1:0]   off_q;
  logic               taken_q;

  logic [ADDR_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr;
  logic [CNT_W-1:0]   ras_cnt;

  logic [ADDR_W-1:0]  step;
  logic [ADDR_W-1:0]  link;
  logic [ADDR_W-1:0]  sext_off;
  logic [ADDR_W-1:0]  next_tgt;
  logic [ADDR_W-1:0]  top_entry;

  assign step      = ADDR_W'(1) << SHIFT;
  assign link      = pc_q + step;
  assign sext_off  = {{(ADDR_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  // ras_ptr names the next free slot, so the newest entry sits one below it.
  assign top_entry = ras_mem[ras_ptr - PTR_W'(1)];

  always_comb begin
    next_tgt = link;
    case (op_q)
      OP_J, OP_JAL: next_tgt = {pc_q[ADDR_W-1 -: 4], idx_q, {SHIFT{1'b0}}};
      OP_BR:        next_tgt = taken_q ? (link + (sext_off << SHIFT)) : link;
      OP_JR, OP_RET: next_tgt = rs_q;
      default:      next_tgt = link;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      tgt_valid <= 1'b0;
      tgt_addr  <= '0;
      link_addr <= '0;
      ras_hit   <= 1'b0;
      ras_empty <= 1'b0;
      op_err    <= 1'b0;
      ras_ptr   <= '0;
      ras_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= op;
            pc_q      <= pc;
            rs_q      <= rs_val;
            idx_q     <= instr_index;
            off_q     <= offset;
            taken_q   <= br_taken;
            req_ready <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          tgt_addr  <= next_tgt;
          link_addr <= link;
          op_err    <= (op_q > OP_RET);
          ras_hit   <= 1'b0;
          ras_empty <= 1'b0;
          if (op_q == OP_JAL) begin
            // A full stack wraps and silently drops its oldest entry.
            ras_mem[ras_ptr] <= link;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            if (ras_cnt != CNT_W'(RAS_DEPTH))
              ras_cnt <= ras_cnt + CNT_W'(1);
          end else if (op_q == OP_RET) begin
            if (ras_cnt == '0) begin
              ras_empty <= 1'b1;
            end else begin
              ras_hit <= (top_entry == rs_q);
              ras_ptr <= ras_ptr - PTR_W'(1);
              ras_cnt <= ras_cnt - CNT_W'(1);
            end
          end
          tgt_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (tgt_ready) begin
            tgt_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          tgt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_target_unit.sv
// tb/tb_jump_target_unit.sv - randomized, model-checked bench for jump_target_unit
module tb_jump_target_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] pc;
  logic [25:0] instr_index;
  logic [15:0] offset;
  logic [31:0] rs_val;
  logic        br_taken;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [31:0] tgt_addr;
  logic [31:0] link_addr;
  logic        ras_hit;
  logic        ras_empty;
  logic        op_err;

  jump_target_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .pc(pc), .instr_index(instr_index), .offset(offset),
    .rs_val(rs_val), .br_taken(br_taken), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .tgt_addr(tgt_addr), .link_addr(link_addr),
    .ras_hit(ras_hit), .ras_empty(ras_empty), .op_err(op_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] ras_model [$];
  logic        pending = 1'b0;
  logic [31:0] e_tgt, e_link;
  logic        e_hit, e_empty, e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Compare process: whenever a target is presented it must match the model.
  always @(negedge clk) begin
    if (!reset && tgt_valid) begin
      chk("valid_expected", 32'(pending), 32'd1);
      chk("tgt_addr", tgt_addr, e_tgt);
      chk("link_addr", link_addr, e_link);
      chk("ras_hit", 32'(ras_hit), 32'(e_hit));
      chk("ras_empty", 32'(ras_empty), 32'(e_empty));
      chk("op_err", 32'(op_err), 32'(e_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
  end

  task automatic model(input logic [2:0] o, input logic [31:0] p, input logic [25:0] idx,
                       input logic [15:0] off, input logic tk, input logic [31:0] rs);
    logic signed [31:0] so;
    logic [31:0] v;
    so      = 32'($signed(off));
    e_link  = p + 32'd4;
    e_hit   = 1'b0;
    e_empty = 1'b0;
    e_err   = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        e_tgt = (p & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
        if (o == 3'd1) begin
          if (ras_model.size() == 4) void'(ras_model.pop_front());
          ras_model.push_back(p + 32'd4);
        end
      end
      3'd2: e_tgt = tk ? p + 32'd4 + 32'(so * 32'sd4) : p + 32'd4;
      3'd3: e_tgt = rs;
      3'd4: begin
        e_tgt = rs;
        if (ras_model.size() == 0) e_empty = 1'b1;
        else begin
          v = ras_model.pop_back();
          e_hit = (v == rs);
        end
      end
      default: begin
        e_tgt = p + 32'd4;
        e_err = 1'b1;
      end
    endcase
  endtask

  task automatic do_req(input logic [2:0] o, input logic [31:0] p, input logic [25:0] idx,
                        input logic [15:0] off, input logic tk, input logic [31:0] rs,
                        input int hold);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    model(o, p, idx, off, tk, rs);
    pending     = 1'b1;
    op          = o;
    pc          = p;
    instr_index = idx;
    offset      = off;
    br_taken    = tk;
    rs_val      = rs;
    tgt_ready   = 1'b0;
    req_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    op = $urandom_range(7, 0);
    pc = $urandom;
    rs_val = $urandom;
    chk("calc_tgt_valid", 32'(tgt_valid), 32'd0);
    chk("calc_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("latency_tgt_valid", 32'(tgt_valid), 32'd1);
    repeat (hold) @(negedge clk);
    tgt_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tgt_ready = 1'b0;
    pending   = 1'b0;
    chk("done_tgt_valid", 32'(tgt_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; tgt_ready = 1'b0; op = 3'd0; pc = '0;
    instr_index = '0; offset = '0; rs_val = '0; br_taken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_tgt_valid", 32'(tgt_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_tgt_addr", tgt_addr, 32'd0);
    chk("rst_link_addr", link_addr, 32'd0);
    chk("rst_flags", {29'd0, ras_hit, ras_empty, op_err}, 32'd0);

    do_req(3'd0, 32'hA000_0010, 26'h0000123, 16'h0, 1'b0, 32'h0, 0);
    chk("lit_j", tgt_addr, 32'hA000_048C);
    chk("lit_j_err", 32'(op_err), 32'd0);
    do_req(3'd2, 32'h0040_0100, 26'h0, 16'hFFFE, 1'b1, 32'h0, 1);
    chk("lit_br_taken", tgt_addr, 32'h0040_00FC);
    do_req(3'd2, 32'h0040_0100, 26'h0, 16'hFFFE, 1'b0, 32'h0, 0);
    chk("lit_br_not", tgt_addr, 32'h0040_0104);

    do_req(3'd1, 32'h0040_0020, 26'h1, 16'h0, 1'b0, 32'h0, 0);
    chk("lit_jal_link", link_addr, 32'h0040_0024);
    do_req(3'd4, 32'h0, 26'h0, 16'h0, 1'b0, 32'h0040_0024, 0);
    chk("lit_ret_hit", {30'd0, ras_hit, ras_empty}, 32'd2);
    do_req(3'd1, 32'h0040_0020, 26'h1, 16'h0, 1'b0, 32'h0, 0);
    do_req(3'd4, 32'h0, 26'h0, 16'h0, 1'b0, 32'h0040_0028, 0);
    chk("lit_ret_miss", {30'd0, ras_hit, ras_empty}, 32'd0);
    chk("lit_ret_tgt", tgt_addr, 32'h0040_0028);

    for (int i = 1; i <= 5; i++)
      do_req(3'd1, 32'(i * 16), 26'h0, 16'h0, 1'b0, 32'h0, 0);
    for (int i = 5; i >= 2; i--) begin
      do_req(3'd4, 32'h0, 26'h0, 16'h0, 1'b0, 32'(i * 16 + 4), 0);
      chk("lit_ras_pop", 32'(ras_hit), 32'd1);
    end
    do_req(3'd4, 32'h0, 26'h0, 16'h0, 1'b0, 32'h14, 6);
    chk("lit_ras_empty", {30'd0, ras_hit, ras_empty}, 32'd1);

    do_req(3'd1, 32'h0000_0100, 26'h0, 16'h0, 1'b0, 32'h0, 0);
    @(negedge clk);
    op = 3'd1; pc = 32'h0000_0200; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ras_model.delete();
    chk("midrst_tgt_valid", 32'(tgt_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_tgt_addr", tgt_addr, 32'd0);
    do_req(3'd4, 32'h0, 26'h0, 16'h0, 1'b0, 32'h204, 0);
    chk("lit_rst_ras_cnt0", 32'(ras_empty), 32'd1);
    do_req(3'd7, 32'h1234_5670, 26'h0, 16'h0, 1'b0, 32'h0, 0);
    chk("lit_illegal_err", 32'(op_err), 32'd1);
    chk("lit_illegal_tgt", tgt_addr, 32'h1234_5674);

    for (int i = 0; i < 300; i++) begin
      logic [2:0]  o;
      logic [31:0] rs;
      o  = (i % 3 == 0) ? 3'd1 : 3'($urandom_range(7, 0));
      rs = $urandom;
      if (o == 3'd4 && ras_model.size() > 0 && $urandom_range(1, 0) == 1)
        rs = ras_model[ras_model.size() - 1];
      do_req(o, $urandom, 26'($urandom), 16'($urandom), 1'($urandom), rs,
             $urandom_range(3, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
